pa_range_stats: RTL and testbench

Parametrised range-statistics engine that streams a contiguous address window out of a single-port synchronous RAM and returns its mean, sum, minimum or maximum. It succeeds the fixed mean calculator in the processing-array datapath. Over that block it adds an inclusive element count, a selectable reduction mode, ordered-range error detection, a busy/done handshake, and a full-width result held until the next request. It sits between the array controller, which issues requests, and the sample RAM, which it reads.

---
 rtl/pa_stats_pkg.sv | 28 ++
 rtl/pa_seq_divider.sv | 79 +++++++
 rtl/pa_range_stats.sv | 163 ++++++++++++++++
 tb/tb_pa_range_stats.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_stats_pkg.sv
// Shared types and helpers for the range-statistics engine.
//   mode_e     : reduction selected with each request
//   state_e    : sequencer states of pa_range_stats
//   calc_acc_w : accumulator width needed to sum a full window without overflow
package pa_stats_pkg;

  typedef enum logic [1:0] {
    MODE_MEAN = 2'b00,
    MODE_SUM  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_MAX  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DIV,
    S_DONE
  } state_e;

  // A window holds at most 2^addr_w words of at most 2^data_w-1 each, so the
  // sum always fits in data_w+addr_w bits.
  function automatic int calc_acc_w(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

endpackage

// File: rtl/pa_seq_divider.sv
// Restoring sequential divider, one quotient bit per clock.
//   i_start      : loads dividend/divisor and performs the first step at once
//   i_dividend   : W-bit unsigned dividend, sampled with i_start
//   i_divisor    : W-bit unsigned divisor, sampled with i_start
//   o_valid      : one-cycle pulse when the quotient/remainder are final
//   o_quotient   : floor(dividend / divisor); all ones when divisor is 0
//   o_remainder  : dividend mod divisor
// Latency: o_valid is high in the cycle after the (W-1)th edge following the
// edge that samples i_start. A new i_start restarts the division.
module pa_seq_divider #(
  parameter int W = 14
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_valid,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q, quo_q, dsr_q;
  logic [W-1:0]  src_rem, src_quo, dsr;
  logic [W:0]    rem_sh, diff;
  logic [W-1:0]  rem_nxt, quo_nxt;

  // One restoring step. On i_start the step runs on the fresh operands, so
  // the load edge already produces the first quotient bit.
  // NOTE: every always_comb output gets a value on every path (here via the
  // full if/else); a missing branch would infer a latch.
  always_comb begin
    src_rem = i_start ? '0 : rem_q;
    src_quo = i_start ? i_dividend : quo_q;
    dsr     = i_start ? i_divisor : dsr_q;
    rem_sh  = {src_rem, src_quo[W-1]};
    diff    = rem_sh - {1'b0, dsr};
    if (diff[W]) begin
      // Restore: shifted remainder is below the divisor, so bit W is zero.
      rem_nxt = rem_sh[W-1:0];
      quo_nxt = {src_quo[W-2:0], 1'b0};
    end else begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {src_quo[W-2:0], 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_start) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        dsr_q <= i_divisor;
        cnt_q <= CW'(W - 1);
      end else if (cnt_q != '0) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) o_valid <= 1'b1;
      end
    end
  end

  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;

endmodule

// File: rtl/pa_range_stats.sv
// Range-statistics engine: streams RAM[si..ei] and returns mean/sum/min/max.
//   i_start/i_mode/i_addr_si/i_addr_ei : request, sampled when o_busy=0
//   o_re_ram/o_addr_ram/i_data_ram     : single-port RAM, 1-cycle read latency
//   o_busy   : from the cycle after an accepted request through o_done
//   o_result : full-width result, held until the next successful request
//   o_err    : with o_done, 1 when i_addr_ei < i_addr_si (no reads issued)
//   o_done   : one-cycle completion pulse
module pa_range_stats
  import pa_stats_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int ACC_W      = calc_acc_w(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_addr_si,
  input  logic [ADDR_WIDTH-1:0] i_addr_ei,
  input  logic [DATA_WIDTH-1:0] i_data_ram,
  output logic                  o_re_ram,
  output logic [ADDR_WIDTH-1:0] o_addr_ram,
  output logic                  o_busy,
  output logic [ACC_W-1:0]      o_result,
  output logic                  o_err,
  output logic                  o_done
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  state_e                state_q;
  mode_e                 mode_q;
  logic [ADDR_WIDTH-1:0] ei_q;
  logic [CNT_W-1:0]      n_q;
  logic                  err_q;
  logic                  rd_vld_q;

  logic [ACC_W-1:0]      acc_q, acc_nxt;
  logic [DATA_WIDTH-1:0] min_q, max_q, min_nxt, max_nxt;

  logic                  div_start, div_valid;
  logic [ACC_W-1:0]      div_quo, div_rem_unused;

  // Fold the datum returned for the read issued in the previous cycle.
  always_comb begin
    acc_nxt = acc_q;
    min_nxt = min_q;
    max_nxt = max_q;
    if (rd_vld_q) begin
      acc_nxt = acc_q + ACC_W'(i_data_ram);
      if (i_data_ram < min_q) min_nxt = i_data_ram;
      if (i_data_ram > max_q) max_nxt = i_data_ram;
    end
  end

  // The divider is launched on the edge that folds the last datum, so it is
  // fed the post-fold sum rather than the registered one.
  assign div_start = (state_q == S_DRAIN) && (mode_q == MODE_MEAN);

  pa_seq_divider #(
    .W (ACC_W)
  ) u_div (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (div_start),
    .i_dividend  (acc_nxt),
    .i_divisor   (ACC_W'(n_q)),
    .o_valid     (div_valid),
    .o_quotient  (div_quo),
    .o_remainder (div_rem_unused)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_MEAN;
      ei_q       <= '0;
      n_q        <= '0;
      err_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      acc_q      <= '0;
      min_q      <= '1;
      max_q      <= '0;
      o_re_ram   <= 1'b0;
      o_addr_ram <= '0;
      o_busy     <= 1'b0;
      o_result   <= '0;
      o_err      <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      rd_vld_q <= o_re_ram;
      acc_q    <= acc_nxt;
      min_q    <= min_nxt;
      max_q    <= max_nxt;

      case (state_q)
        S_IDLE: begin
          o_done <= 1'b0;
          o_err  <= 1'b0;
          // o_busy is still high in the o_done cycle, which keeps a request
          // arriving then from being accepted.
          if (i_start && !o_busy) begin
            mode_q <= mode_e'(i_mode);
            ei_q   <= i_addr_ei;
            o_busy <= 1'b1;
            if (i_addr_ei < i_addr_si) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q      <= 1'b0;
              n_q        <= {1'b0, i_addr_ei} - {1'b0, i_addr_si} + CNT_W'(1);
              acc_q      <= '0;
              min_q      <= '1;
              max_q      <= '0;
              o_re_ram   <= 1'b1;
              o_addr_ram <= i_addr_si;
              state_q    <= S_READ;
            end
          end else begin
            o_busy <= 1'b0;
          end
        end

        S_READ: begin
          // Stop on ei itself so the counter never wraps past the window.
          if (o_addr_ram == ei_q) begin
            o_re_ram <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            o_addr_ram <= o_addr_ram + ADDR_WIDTH'(1);
          end
        end

        S_DRAIN: begin
          state_q <= (mode_q == MODE_MEAN) ? S_DIV : S_DONE;
        end

        S_DIV: begin
          if (div_valid) state_q <= S_DONE;
        end

        S_DONE: begin
          o_done  <= 1'b1;
          o_err   <= err_q;
          state_q <= S_IDLE;
          if (!err_q) begin
            case (mode_q)
              MODE_MEAN: o_result <= div_quo;
              MODE_SUM:  o_result <= acc_q;
              MODE_MIN:  o_result <= ACC_W'(min_q);
              MODE_MAX:  o_result <= ACC_W'(max_q);
              default:   o_result <= acc_q;
            endcase
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pa_range_stats.sv
module tb_pa_range_stats;
  import pa_stats_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int ACCW  = 14;
  localparam int LIMIT = 200;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic [1:0]      i_mode;
  logic [AW-1:0]   i_addr_si, i_addr_ei;
  logic [DW-1:0]   ram_q;
  logic            o_re_ram;
  logic [AW-1:0]   o_addr_ram;
  logic            o_busy;
  logic [ACCW-1:0] o_result;
  logic            o_err;
  logic            o_done;

  logic [DW-1:0]   mem [64];

  int checks   = 0;
  int failures = 0;
  int last_res = 0;

  pa_range_stats #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_addr_si  (i_addr_si),
    .i_addr_ei  (i_addr_ei),
    .i_data_ram (ram_q),
    .o_re_ram   (o_re_ram),
    .o_addr_ram (o_addr_ram),
    .o_busy     (o_busy),
    .o_result   (o_result),
    .o_err      (o_err),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk) if (o_re_ram) ram_q <= mem[o_addr_ram];

  // Reference: reduce the window with plain integer arithmetic.
  function automatic int model_result(input logic [1:0] mode, input int si, input int ei);
    int sum = 0, mn = 255, mx = 0;
    for (int a = si; a <= ei; a++) begin
      sum += int'(mem[a]);
      if (int'(mem[a]) < mn) mn = int'(mem[a]);
      if (int'(mem[a]) > mx) mx = int'(mem[a]);
    end
    case (mode)
      2'b00:   return sum / (ei - si + 1);
      2'b01:   return sum;
      2'b10:   return mn;
      default: return mx;
    endcase
  endfunction

  function automatic int model_done_k(input logic [1:0] mode, input int si, input int ei);
    if (ei < si) return 1;
    return (mode == 2'b00) ? (ei - si + 1) + 2 + ACCW : (ei - si + 1) + 2;
  endfunction

  // Issue one request and observe it. done_k counts edges after the sampling
  // edge E0; -1 means o_done never came. Optionally injects a second request
  // right after the sample at index inj_k.
  task automatic run_op(input logic [1:0] mode, input int si, input int ei,
                        input int inj_k, input logic [1:0] inj_mode, input int inj_si, input int inj_ei,
                        output int done_k, output int reads, output logic err_seen,
                        output int res, output logic order_ok, output logic busy_ok);
    @(negedge clk);
    i_start = 1'b1; i_mode = mode; i_addr_si = AW'(si); i_addr_ei = AW'(ei);
    @(posedge clk); #1;
    i_start = 1'b0;
    done_k = -1; reads = 0; err_seen = 1'b0; res = -1; order_ok = 1'b1; busy_ok = 1'b1;
    for (int k = 0; k < LIMIT; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == inj_k) begin
        i_start = 1'b1; i_mode = inj_mode; i_addr_si = AW'(inj_si); i_addr_ei = AW'(inj_ei);
      end else begin
        i_start = 1'b0;
      end
      if (o_re_ram) begin
        if (int'(o_addr_ram) != si + reads) order_ok = 1'b0;
        reads++;
      end
      if (!o_busy) busy_ok = 1'b0;
      if (o_done) begin
        done_k = k; err_seen = o_err; res = int'(o_result);
        break;
      end
    end
    i_start = 1'b0;
    @(posedge clk); #1;
    if (o_busy || o_done) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_mode = '0; i_addr_si = '0; i_addr_ei = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_re_ram, o_addr_ram, o_busy, o_result, o_err, o_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got re=%b addr=%0d busy=%b res=%0d err=%b done=%b, want all 0",
               o_re_ram, o_addr_ram, o_busy, o_result, o_err, o_done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_re_ram, o_busy, o_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle: got re=%b busy=%b done=%b, want 0 0 0", o_re_ram, o_busy, o_done);
    end
    last_res = 0;
  endtask

  task automatic test_fixed_window();
    int exp_res [4] = '{25, 101, 10, 41};
    int exp_k   [4] = '{20, 6, 6, 6};
    int dk, rd, res; logic er, ok, bz;
    for (int a = 0; a < 64; a++) mem[a] = 8'd0;
    mem[4] = 8'd10; mem[5] = 8'd20; mem[6] = 8'd30; mem[7] = 8'd41;
    for (int m = 0; m < 4; m++) begin
      run_op(2'(m), 4, 7, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
      checks++;
      if (res !== exp_res[m] || er !== 1'b0) begin
        failures++;
        $display("FAIL fixed_result mode=%0d: got %0d err=%b, want %0d err=0", m, res, er, exp_res[m]);
      end
      checks++;
      if (dk !== exp_k[m]) begin
        failures++;
        $display("FAIL fixed_done_time mode=%0d: got E0+%0d, want E0+%0d", m, dk, exp_k[m]);
      end
      checks++;
      if (rd !== 4 || !ok || !bz) begin
        failures++;
        $display("FAIL fixed_reads mode=%0d: got reads=%0d order_ok=%b busy_ok=%b, want 4 1 1", m, rd, ok, bz);
      end
      last_res = exp_res[m];
    end
  endtask

  task automatic test_single();
    int dk, rd, res; logic er, ok, bz;
    mem[9] = 8'd200;
    run_op(MODE_MEAN, 9, 9, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
    checks++;
    if (res !== 200 || dk !== 17 || rd !== 1 || !ok || !bz) begin
      failures++;
      $display("FAIL single_word: got res=%0d done=E0+%0d reads=%0d ok=%b busy=%b, want 200 E0+17 1 1 1",
               res, dk, rd, ok, bz);
    end
    last_res = 200;
  endtask

  task automatic test_full_window();
    int dk, rd, res; logic er, ok, bz;
    for (int a = 0; a < 64; a++) mem[a] = 8'hFF;
    run_op(MODE_SUM, 0, 63, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
    checks++;
    if (res !== 16320 || dk !== 66 || rd !== 64 || !ok || !bz) begin
      failures++;
      $display("FAIL full_sum: got res=%0d done=E0+%0d reads=%0d ok=%b busy=%b, want 16320 E0+66 64 1 1",
               res, dk, rd, ok, bz);
    end
    run_op(MODE_MEAN, 0, 63, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
    checks++;
    if (res !== 255 || dk !== 80 || rd !== 64 || !ok || !bz) begin
      failures++;
      $display("FAIL full_mean: got res=%0d done=E0+%0d reads=%0d ok=%b busy=%b, want 255 E0+80 64 1 1",
               res, dk, rd, ok, bz);
    end
    last_res = 255;
  endtask

  task automatic test_err();
    int dk, rd, res; logic er, ok, bz;
    run_op(MODE_SUM, 10, 3, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
    checks++;
    if (er !== 1'b1 || dk !== 1 || rd !== 0 || !bz) begin
      failures++;
      $display("FAIL err_flag: got err=%b done=E0+%0d reads=%0d busy=%b, want 1 E0+1 0 1", er, dk, rd, bz);
    end
    checks++;
    if (res !== last_res || int'(o_result) !== last_res) begin
      failures++;
      $display("FAIL err_holds_result: got %0d/%0d, want %0d", res, o_result, last_res);
    end
  endtask

  task automatic test_busy_ignore();
    int dk, rd, res; logic er, ok, bz;
    for (int a = 0; a < 64; a++) mem[a] = 8'd1;
    mem[4] = 8'd10; mem[5] = 8'd20; mem[6] = 8'd30; mem[7] = 8'd41;
    run_op(MODE_MEAN, 4, 7, 1, MODE_SUM, 0, 63, dk, rd, er, res, ok, bz);
    checks++;
    if (res !== 25 || dk !== 20 || rd !== 4 || !ok || !bz) begin
      failures++;
      $display("FAIL busy_ignore: got res=%0d done=E0+%0d reads=%0d ok=%b busy=%b, want 25 E0+20 4 1 1",
               res, dk, rd, ok, bz);
    end
    last_res = 25;
  endtask

  task automatic test_reset_mid_div();
    int dk, rd, res; logic er, ok, bz;
    logic done_seen;
    @(negedge clk);
    i_start = 1'b1; i_mode = MODE_MEAN; i_addr_si = AW'(4); i_addr_ei = AW'(7);
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_re_ram, o_addr_ram, o_busy, o_result, o_err, o_done} !== '0) begin
      failures++;
      $display("FAIL reset_mid_div: got re=%b addr=%0d busy=%b res=%0d err=%b done=%b, want all 0",
               o_re_ram, o_addr_ram, o_busy, o_result, o_err, o_done);
    end
    done_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (o_done) done_seen = 1'b1; end
    rst_n = 1'b1;
    repeat (30) begin @(negedge clk); if (o_done || o_busy) done_seen = 1'b1; end
    checks++;
    if (done_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: got activity=%b, want 0", done_seen);
    end
    run_op(MODE_SUM, 4, 7, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
    checks++;
    if (res !== 101 || dk !== 6 || rd !== 4 || !ok || !bz) begin
      failures++;
      $display("FAIL reset_recover: got res=%0d done=E0+%0d reads=%0d, want 101 E0+6 4", res, dk, rd);
    end
    last_res = 101;
  endtask

  task automatic test_back_to_back();
    int dk, rd, res; logic er, ok, bz;
    run_op(MODE_MAX, 4, 7, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
    run_op(MODE_MIN, 5, 6, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
    checks++;
    if (res !== 20 || dk !== 4 || rd !== 2 || !ok || !bz) begin
      failures++;
      $display("FAIL back_to_back: got res=%0d done=E0+%0d reads=%0d, want 20 E0+4 2", res, dk, rd);
    end
    last_res = 20;
  endtask

  task automatic test_random();
    int dk, rd, res, si, ei, exp_r, exp_k; logic er, ok, bz;
    logic [1:0] mode;
    for (int it = 0; it < 24; it++) begin
      for (int a = 0; a < 64; a++) begin
        case ($urandom_range(0, 5))
          0:       mem[a] = 8'd0;
          1:       mem[a] = 8'hFF;
          default: mem[a] = 8'($urandom_range(0, 255));
        endcase
      end
      mode = 2'($urandom_range(0, 3));
      si   = int'($urandom_range(0, 63));
      ei   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(si, 63));
      exp_k = model_done_k(mode, si, ei);
      exp_r = (ei < si) ? last_res : model_result(mode, si, ei);
      run_op(mode, si, ei, -1, 2'b00, 0, 0, dk, rd, er, res, ok, bz);
      checks++;
      if (res !== exp_r || er !== (ei < si)) begin
        failures++;
        $display("FAIL rand_result it=%0d mode=%0d si=%0d ei=%0d: got %0d err=%b, want %0d err=%b",
                 it, mode, si, ei, res, er, exp_r, (ei < si));
      end
      checks++;
      if (dk !== exp_k || rd !== ((ei < si) ? 0 : ei - si + 1) || !ok || !bz) begin
        failures++;
        $display("FAIL rand_timing it=%0d: got done=E0+%0d reads=%0d ok=%b busy=%b, want E0+%0d reads=%0d",
                 it, dk, rd, ok, bz, exp_k, (ei < si) ? 0 : ei - si + 1);
      end
      last_res = exp_r;
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 8'd0;
    test_reset();
    test_fixed_window();
    test_single();
    test_full_window();
    test_err();
    test_busy_ignore();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
